aes128_key_sched: RTL
=====================

// Module: aes128_key_sched
// PURPOSE
//  Iterative AES-128 key schedule (FIPS-197 KeyExpansion). Loads one 128-bit cipher key.
//  Emits the 11 round keys rk0..rk10 in order over a valid/ready stream.
//  Feeds the AddRoundKey XOR stage of the aes128 round datapath (built from library cells).
//  One round key is computed per accepted handshake.
// PARAMETERS
//  NUM_RK   11   number of round keys emitted (AES-128 only; other values unsupported)
//  IDX_W    4    width of round-key index output
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  key_in    in   128    cipher key, byte 0 = key_in[127:120]; sampled only on accepted load
//  key_load  in   1      load request; accepted only in IDLE
//  rk_ready  in   1      downstream can take rk_out this cycle
//  rk_valid  out  1      rk_out/rk_idx hold a valid round key
//  rk_out    out  128    current round key, same byte order as key_in
//  rk_idx    out  IDX_W  index of rk_out, 0..10
//  busy      out  1      high in EXPAND state
//  done      out  1      one-cycle pulse after rk10 handshake
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; rk_valid=0, rk_out=0, rk_idx=0, busy=0, done=0, rcon=8'h01.
//  Reset mid-expansion aborts immediately; no further keys are emitted and no done pulse is produced.
//  States: IDLE -> EXPAND on key_load. EXPAND -> IDLE on handshake with rk_idx==10.
//  IDLE + key_load at edge N: at N+1, rk_out=key_in, rk_idx=0, rk_valid=1, busy=1, rcon=01.
//  Handshake = rk_valid & rk_ready at a posedge.
//  EXPAND, handshake, rk_idx<10: next edge rk_out=f(rk_out,rcon), rk_idx+=1, rcon=xtime(rcon).
//  rk_valid stays 1 between keys: a 1-key-per-cycle stream with no bubbles.
//  EXPAND, no handshake: rk_out, rk_idx and rcon hold. Stall of any length is legal.
//  EXPAND, handshake, rk_idx==10: next edge rk_valid=0, busy=0, done=1 for exactly one cycle.
//  rk_out and rk_idx keep their last values after done.
//  key_load while in EXPAND: ignored; no state change and key_in not sampled.
//  key_load in the cycle done=1 (state already IDLE): accepted normally.
//  f(): w0..w3 = 32-bit words of rk_out, w0 = MSW.
//  t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord = {w3[23:0], w3[31:24]}.
//  w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
//  SubWord: 4 parallel copies of the FIPS-197 S-box.
//  Implement the S-box as a combinational 256x8 case ROM; no memory macro.
//  rcon sequence: 01 02 04 08 10 20 40 80 1B 36.
//  xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00).
//  All outputs are registered; no combinational path from inputs to outputs.
//  Critical path: one S-box plus 4 chained XORs.
// TESTING
//  1 FIPS-197 A.1, rk_ready tied 1: load key 2b7e151628aed2a6abf7158809cf4f3c.
//    -> rk0 = key at load+1.
//    -> rk1 = a0fafe1788542cb123a339392a6c7605 at load+2.
//    -> rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at load+11.
//    -> done=1 at load+12.
//  2 Backpressure: same key, rk_ready toggles 1,0,0,1,...
//    -> keys identical to test 1; rk_out and rk_idx stable while rk_ready=0.
//    -> exactly 11 handshakes; rk_valid never drops before rk10.
//  3 Load during busy: key_load with key 000102030405060708090a0b0c0d0e0f at rk_idx=3.
//    -> ignored; stream continues with the original key through rk10.
//  4 Reset mid-operation: rst=1 at rk_idx=5.
//    -> next cycle rk_valid=0, busy=0, rk_idx=0, rk_out=0, done=0.
//    -> a new load of key 000102...0f yields rk1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
//  5 Back-to-back: key_load asserted in the done cycle with key 000102...0f.
//    -> rk_valid=1, rk_idx=0, rk_out=000102...0f on the next cycle.
//  6 All-zero key: load 0.
//    -> rk1 = 62636363626363636263636362636363.
//    -> rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.

Source files
------------

// File: rtl/aes128_key_sched.sv
// -----------------------------------------------------------------------------
// aes128_key_sched
//   Iterative AES-128 key expansion. A cipher key is captured on an accepted
//   load request in IDLE, then the eleven round keys rk0..rk10 are streamed
//   out in order over a valid/ready interface, one new key per handshake.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous, active-high reset
//   key_in    in   128    cipher key, byte 0 = key_in[127:120]
//   key_load  in   1      load request, accepted only in IDLE
//   rk_ready  in   1      downstream can take rk_out this cycle
//   rk_valid  out  1      rk_out/rk_idx hold a valid round key
//   rk_out    out  128    current round key, same byte order as key_in
//   rk_idx    out  IDX_W  index of rk_out, 0..10
//   busy      out  1      high while expanding
//   done      out  1      one-cycle pulse after the rk10 handshake
// -----------------------------------------------------------------------------
module aes128_key_sched #(
    parameter int NUM_RK = 11,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     key_in,
    input  logic             key_load,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [127:0]     rk_out,
    output logic [IDX_W-1:0] rk_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state_r;
    state_t             next_state_s;
    logic               load_s;
    logic               step_s;
    logic               finish_s;
    logic               handshake_s;
    logic               last_s;

    logic               rk_valid_r;
    logic [127:0]       rk_out_r;
    logic [IDX_W-1:0]   rk_idx_r;
    logic [7:0]         rcon_r;
    logic               busy_r;
    logic               done_r;

    logic [31:0]        w0_s;
    logic [31:0]        w1_s;
    logic [31:0]        w2_s;
    logic [31:0]        w3_s;
    logic [31:0]        rot_s;
    logic [31:0]        t_s;
    logic [31:0]        n0_s;
    logic [31:0]        n1_s;
    logic [31:0]        n2_s;
    logic [31:0]        n3_s;
    logic [127:0]       next_rk_s;

    // FIPS-197 forward S-box as a combinational case ROM
    function automatic logic [7:0] sbox(input logic [7:0] a);
        case (a)
            8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
            8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
            8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
            8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
            8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
            8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
            8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
            8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
            8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
            8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
            8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
            8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
            8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
            8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
            8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
            8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
            8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
            8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
            8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
            8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
            8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
            8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
            8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
            8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
            8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
            8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
            8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
            8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
            8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
            8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
            8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
            8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
            default: sbox = 8'h00;
        endcase
    endfunction

    // GF(2^8) multiply-by-2 used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] r);
        xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    assign handshake_s = rk_valid_r & rk_ready;
    assign last_s      = (rk_idx_r == LAST_IDX);

    // Next round key: one S-box layer on the rotated last word, then the word XOR chain
    assign w0_s  = rk_out_r[127:96];
    assign w1_s  = rk_out_r[95:64];
    assign w2_s  = rk_out_r[63:32];
    assign w3_s  = rk_out_r[31:0];
    assign rot_s = {w3_s[23:0], w3_s[31:24]};
    assign t_s   = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])}
                   ^ {rcon_r, 24'h000000};
    assign n0_s  = w0_s ^ t_s;
    assign n1_s  = w1_s ^ n0_s;
    assign n2_s  = w2_s ^ n1_s;
    assign n3_s  = w3_s ^ n2_s;
    assign next_rk_s = {n0_s, n1_s, n2_s, n3_s};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and datapath control strobes
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (key_load) begin
                    next_state_s = ST_EXPAND;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                // key_load is deliberately not looked at here
                if (handshake_s) begin
                    if (last_s) begin
                        next_state_s = ST_IDLE;
                        finish_s     = 1'b1;
                    end else begin
                        step_s       = 1'b1;
                    end
                end else begin
                    next_state_s = ST_EXPAND;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Round-key datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid_r <= 1'b0;
            rk_out_r   <= 128'h0;
            rk_idx_r   <= {IDX_W{1'b0}};
            rcon_r     <= 8'h01;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (load_s) begin
                rk_valid_r <= 1'b1;
                rk_out_r   <= key_in;
                rk_idx_r   <= {IDX_W{1'b0}};
                rcon_r     <= 8'h01;
            end else if (step_s) begin
                rk_valid_r <= 1'b1;
                rk_out_r   <= next_rk_s;
                rk_idx_r   <= rk_idx_r + IDX_ONE;
                rcon_r     <= xtime(rcon_r);
            end else if (finish_s) begin
                // rk_out/rk_idx intentionally keep the rk10 values
                rk_valid_r <= 1'b0;
            end else begin
                rk_valid_r <= rk_valid_r;
                rk_out_r   <= rk_out_r;
                rk_idx_r   <= rk_idx_r;
                rcon_r     <= rcon_r;
            end
            busy_r <= (next_state_s == ST_EXPAND);
            done_r <= finish_s;
        end
    end

    assign rk_valid = rk_valid_r;
    assign rk_out   = rk_out_r;
    assign rk_idx   = rk_idx_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
